// File: rtl/me_pkg.sv
// Shared types and constants for the full-search 8x8 block-matching motion estimator.
package me_pkg;
  localparam int BLK       = 8;
  localparam int PIX_W     = 8;
  localparam int SAD_W     = 14;
  localparam int COORD_W   = 5;
  localparam int ROW_SAD_W = 11;

  localparam int ADDR_W    = 32;
  localparam int CUR_BUS_W = 32;
  localparam int REF_BUS_W = 64;
  localparam int CUR_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEARCH,
    DONE
  } me_state_e;

  function automatic int ref_width(input int search_range);
    return search_range + BLK - 1;
  endfunction
endpackage

// File: rtl/motion_estimator_if.sv
// Read bus between the motion estimator and its current/reference frame memories.
interface motion_estimator_if;
  import me_pkg::*;

  logic [CUR_BUS_W-1:0] cur_in_i;
  logic [REF_BUS_W-1:0] ref_in_i;
  logic [ADDR_W-1:0]    cur_mem_addr;
  logic [ADDR_W-1:0]    ref_mem_addr;
  logic                 cur_mem_en;
  logic                 ref_mem_en;

  modport master (
    input  cur_in_i,
    input  ref_in_i,
    output cur_mem_addr,
    output ref_mem_addr,
    output cur_mem_en,
    output ref_mem_en
  );

  modport slave (
    output cur_in_i,
    output ref_in_i,
    input  cur_mem_addr,
    input  ref_mem_addr,
    input  cur_mem_en,
    input  ref_mem_en
  );
endinterface

// File: rtl/me_row_sad.sv
// Combinational sum of absolute differences over one 8-pixel row (adder tree).
module me_row_sad
  import me_pkg::*;
(
  input  logic [REF_BUS_W-1:0] cur_row,
  input  logic [REF_BUS_W-1:0] ref_row,
  output logic [ROW_SAD_W-1:0] row_sad
);

  function automatic logic [PIX_W-1:0] pix(input logic [REF_BUS_W-1:0] row, input int j);
    return row[REF_BUS_W-1-PIX_W*j -: PIX_W];
  endfunction

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    logic signed [PIX_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[PIX_W] ? PIX_W'(-d) : PIX_W'(d);
  endfunction

  logic [PIX_W:0]   lvl1 [4];
  logic [PIX_W+1:0] lvl2 [2];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lvl1[k] = {1'b0, abs_diff(pix(cur_row, 2*k),   pix(ref_row, 2*k))}
              + {1'b0, abs_diff(pix(cur_row, 2*k+1), pix(ref_row, 2*k+1))};
    end
    for (int k = 0; k < 2; k++) begin
      lvl2[k] = {1'b0, lvl1[2*k]} + {1'b0, lvl1[2*k+1]};
    end
    row_sad = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};
  end

endmodule

// File: rtl/motion_estimator.sv
// Full-search motion estimator: loads an 8x8 current block, scans every candidate
// in the reference window in raster order and reports the minimum SAD and its offset.
module motion_estimator
  import me_pkg::*;
#(
  parameter int SEARCH_RANGE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  motion_estimator_if.master  mem,
  output logic [SAD_W-1:0]    MSAD,
  output logic [COORD_W-1:0]  MSAD_column,
  output logic [COORD_W-1:0]  MSAD_row,
  output logic                data_valid
);

  localparam int REF_W = ref_width(SEARCH_RANGE);
  localparam logic [COORD_W-1:0] LAST = COORD_W'(SEARCH_RANGE - 1);

  me_state_e state_q, state_d;

  logic                 en_prev_q;
  logic                 start;
  logic [3:0]           ld_cnt_q;
  logic [2:0]           row_i_q;
  logic [COORD_W-1:0]   cand_r_q, cand_c_q;
  logic                 fetch_end_q;
  logic                 fetch, last_fetch;

  logic [REF_BUS_W-1:0] cur_row [BLK];
  logic [ROW_SAD_W-1:0] row_sad;

  logic [ROW_SAD_W-1:0] sad_p0;
  logic [COORD_W-1:0]   r_p0, c_p0;
  logic                 vld_p0, first_p0, last_p0, fin_p0;

  logic [SAD_W-1:0]     acc_p1, total_p1;
  logic                 have_best_q;
  logic [SAD_W-1:0]     best_sad_q;
  logic [COORD_W-1:0]   best_r_q, best_c_q;

  assign start      = en_i & ~en_prev_q;
  assign fetch      = (state_q == SEARCH) && !fetch_end_q;
  assign last_fetch = fetch && (row_i_q == 3'd7) && (cand_r_q == LAST) && (cand_c_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // SEARCH lingers one cycle after the last fetch so the final candidate clears the pipeline.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (ld_cnt_q == 4'd15) state_d = SEARCH;
      SEARCH:  if (fin_p0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_prev_q   <= 1'b0;
      ld_cnt_q    <= '0;
      row_i_q     <= '0;
      cand_r_q    <= '0;
      cand_c_q    <= '0;
      fetch_end_q <= 1'b0;
    end else begin
      en_prev_q <= en_i;
      if (state_q == IDLE) begin
        ld_cnt_q    <= '0;
        row_i_q     <= '0;
        cand_r_q    <= '0;
        cand_c_q    <= '0;
        fetch_end_q <= 1'b0;
      end
      if (state_q == LOAD) begin
        ld_cnt_q <= ld_cnt_q + 4'd1;
      end
      if (fetch) begin
        row_i_q <= row_i_q + 3'd1;
        if (row_i_q == 3'd7) begin
          if (cand_c_q == LAST) begin
            cand_c_q <= '0;
            if (cand_r_q == LAST) fetch_end_q <= 1'b1;
            else                  cand_r_q    <= cand_r_q + 1'b1;
          end else begin
            cand_c_q <= cand_c_q + 1'b1;
          end
        end
      end
    end
  end

  // Even words fill the left half of a block row, odd words the right half.
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      if (ld_cnt_q[0]) cur_row[ld_cnt_q[3:1]][CUR_BUS_W-1:0]         <= mem.cur_in_i;
      else             cur_row[ld_cnt_q[3:1]][REF_BUS_W-1:CUR_BUS_W] <= mem.cur_in_i;
    end
  end

  assign mem.cur_mem_en   = (state_q == LOAD);
  assign mem.cur_mem_addr = mem.cur_mem_en ? ADDR_W'(ld_cnt_q) : '0;
  assign mem.ref_mem_en   = fetch;
  assign mem.ref_mem_addr = fetch ? (ADDR_W'(cand_r_q) + ADDR_W'(row_i_q)) * ADDR_W'(REF_W)
                                    + ADDR_W'(cand_c_q)
                                  : '0;

  me_row_sad u_row_sad (
    .cur_row (cur_row[row_i_q]),
    .ref_row (mem.ref_in_i),
    .row_sad (row_sad)
  );

  // Stage p0: registered row SAD with candidate tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
      fin_p0   <= 1'b0;
    end else begin
      vld_p0   <= fetch;
      first_p0 <= fetch && (row_i_q == 3'd0);
      last_p0  <= fetch && (row_i_q == 3'd7);
      fin_p0   <= last_fetch;
    end
  end

  always_ff @(posedge clk) begin
    sad_p0 <= row_sad;
    r_p0   <= cand_r_q;
    c_p0   <= cand_c_q;
  end

  // Stage p1: candidate accumulation and best-so-far comparison.
  assign total_p1 = first_p0 ? SAD_W'(sad_p0) : acc_p1 + SAD_W'(sad_p0);

  always_ff @(posedge clk) begin
    if (vld_p0) acc_p1 <= total_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_best_q <= 1'b0;
      best_sad_q  <= '0;
      best_r_q    <= '0;
      best_c_q    <= '0;
    end else if (state_q == IDLE && start) begin
      have_best_q <= 1'b0;
    end else if (vld_p0 && last_p0 && (!have_best_q || total_p1 < best_sad_q)) begin
      have_best_q <= 1'b1;
      best_sad_q  <= total_p1;
      best_r_q    <= r_p0;
      best_c_q    <= c_p0;
    end
  end

  assign MSAD        = best_sad_q;
  assign MSAD_row    = best_r_q;
  assign MSAD_column = best_c_q;
  assign data_valid  = (state_q == DONE);

endmodule

// File: tb/tb_motion_estimator.sv
// Directed and randomized bench for motion_estimator against a brute-force SAD model.
module tb_motion_estimator;
  import me_pkg::*;

  localparam int SR         = 4;
  localparam int REF_W      = SR + 7;
  localparam int SEARCH_CYC = 8 * SR * SR;
  localparam int LAT        = 17 + SEARCH_CYC;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic [13:0] MSAD;
  logic [4:0]  MSAD_column;
  logic [4:0]  MSAD_row;
  logic        data_valid;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] cur_px [8][8];
  logic [7:0] ref_px [REF_W*REF_W];

  motion_estimator_if mem ();

  motion_estimator #(.SEARCH_RANGE(SR)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .mem         (mem.master),
    .MSAD        (MSAD),
    .MSAD_column (MSAD_column),
    .MSAD_row    (MSAD_row),
    .data_valid  (data_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    int a;
    mem.cur_in_i = '0;
    a = int'(mem.cur_mem_addr);
    if (mem.cur_mem_en && a < 16)
      for (int j = 0; j < 4; j++) mem.cur_in_i[31-8*j -: 8] = cur_px[a/2][4*(a%2)+j];
  end

  always_comb begin
    int a;
    mem.ref_in_i = '0;
    a = int'(mem.ref_mem_addr);
    if (mem.ref_mem_en && a + 7 < REF_W*REF_W)
      for (int j = 0; j < 8; j++) mem.ref_in_i[63-8*j -: 8] = ref_px[a+j];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int cur_mode, input int ref_mode);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        cur_px[i][j] = (cur_mode < 0) ? 8'($urandom) : 8'(cur_mode);
    for (int k = 0; k < REF_W*REF_W; k++)
      ref_px[k] = (ref_mode < 0) ? 8'($urandom) : 8'(ref_mode);
  endtask

  task automatic plant(input int r, input int c);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) ref_px[(r+i)*REF_W + c + j] = cur_px[i][j];
  endtask

  // Brute-force minimum SAD over the window; strict less-than keeps the first raster hit.
  task automatic model(output logic [13:0] ms, output int br, output int bc);
    int best = -1;
    br = 0; bc = 0;
    for (int r = 0; r < SR; r++)
      for (int c = 0; c < SR; c++) begin
        int s = 0;
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++) begin
            int d = int'(cur_px[i][j]) - int'(ref_px[(r+i)*REF_W + c + j]);
            s += (d < 0) ? -d : d;
          end
        if (best < 0 || s < best) begin
          best = s; br = r; bc = c;
        end
      end
    ms = 14'(best);
  endtask

  task automatic run_search(input string tag);
    int cur_cnt = 0, ref_cnt = 0, en_bad = 0, addr_bad = 0, dv_cnt = 0, dv_k = -1;
    logic [13:0] em;
    int er, ec;
    model(em, er, ec);
    @(posedge clk); #1 en_i = 1'b0;
    @(posedge clk); #1 en_i = 1'b1;
    @(posedge clk);
    for (int k = 0; k < LAT + 40; k++) begin
      int exp_ref;
      @(negedge clk);
      exp_ref = 0;
      if (k >= 16 && k < 16 + SEARCH_CYC) begin
        int m = k - 16;
        int cand = m / 8;
        exp_ref = ((cand / SR) + (m % 8)) * REF_W + (cand % SR);
      end
      if (mem.cur_mem_en === 1'b1) cur_cnt++;
      if (mem.ref_mem_en === 1'b1) ref_cnt++;
      if (mem.cur_mem_en !== (k < 16)) en_bad++;
      if (mem.ref_mem_en !== (k >= 16 && k < 16 + SEARCH_CYC)) en_bad++;
      if (mem.cur_mem_addr !== ((k < 16) ? 32'(k) : 32'd0)) addr_bad++;
      if (mem.ref_mem_addr !== 32'(exp_ref)) addr_bad++;
      if (data_valid === 1'b1) begin
        dv_cnt++;
        if (dv_k < 0) dv_k = k;
      end
    end
    check({tag, " cur_en cycles"}, 32'(cur_cnt), 32'd16);
    check({tag, " ref_en cycles"}, 32'(ref_cnt), 32'(SEARCH_CYC));
    check({tag, " enable pattern"}, 32'(en_bad), 32'd0);
    check({tag, " address pattern"}, 32'(addr_bad), 32'd0);
    check({tag, " valid pulses"}, 32'(dv_cnt), 32'd1);
    check({tag, " valid latency"}, 32'(dv_k), 32'(LAT));
    check({tag, " MSAD"}, 32'(MSAD), 32'(em));
    check({tag, " MSAD_row"}, 32'(MSAD_row), 32'(er));
    check({tag, " MSAD_column"}, 32'(MSAD_column), 32'(ec));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " MSAD"}, 32'(MSAD), 32'd0);
    check({tag, " MSAD_row"}, 32'(MSAD_row), 32'd0);
    check({tag, " MSAD_column"}, 32'(MSAD_column), 32'd0);
    check({tag, " data_valid"}, 32'(data_valid), 32'd0);
    check({tag, " enables"}, {30'd0, mem.cur_mem_en, mem.ref_mem_en}, 32'd0);
    check({tag, " cur_mem_addr"}, mem.cur_mem_addr, 32'd0);
    check({tag, " ref_mem_addr"}, mem.ref_mem_addr, 32'd0);
  endtask

  initial begin
    int dv_cnt;
    rst  = 1'b1;
    en_i = 1'b0;
    fill(0, 0);
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Exact match at (2,1) with en_i left high afterwards.
    fill(-1, -1);
    plant(2, 1);
    run_search("exact");
    check("exact MSAD const", 32'(MSAD), 32'h000);
    check("exact row const", 32'(MSAD_row), 32'd2);
    check("exact col const", 32'(MSAD_column), 32'd1);

    fill(8'h10, 8'h00);
    run_search("tie");
    check("tie MSAD const", 32'(MSAD), 32'h400);
    check("tie pos const", {MSAD_row, MSAD_column}, 32'd0);

    fill(8'hFF, 8'h00);
    run_search("sat");
    check("sat MSAD const", 32'(MSAD), 32'h3FC0);
    check("sat pos const", {MSAD_row, MSAD_column}, 32'd0);

    for (int t = 0; t < 3; t++) begin
      fill(-1, -1);
      run_search($sformatf("rand%0d", t));
    end

    // Reset in the middle of SEARCH.
    fill(-1, -1);
    @(posedge clk); #1 en_i = 1'b0;
    @(posedge clk); #1 en_i = 1'b1;
    repeat (16 + 50) @(posedge clk);
    #1 rst = 1'b1; en_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    rst = 1'b0;
    dv_cnt = 0;
    for (int k = 0; k < LAT + 40; k++) begin
      @(negedge clk);
      if (data_valid === 1'b1) dv_cnt++;
    end
    check("midreset no valid", 32'(dv_cnt), 32'd0);
    run_search("after_reset");

    // Retrigger with the match moved to (3,3).
    fill(-1, -1);
    plant(3, 3);
    run_search("retrigger");
    check("retrigger MSAD const", 32'(MSAD), 32'h000);
    check("retrigger row const", 32'(MSAD_row), 32'd3);
    check("retrigger col const", 32'(MSAD_column), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/motion_estimator.md
Name:
motion_estimator

Overview:
- Full-search block-matching motion estimator for one 8x8 current block (8-bit pixels) against a square reference search window.
- Fetches the current block from a 32-bit current memory and reference rows from a 64-bit reference memory; both memories are combinational read.
- Reports the minimum sum of absolute differences (MSAD) and its (row, column) displacement with a one-cycle valid pulse.
- Sits between the frame-buffer memory models and the downstream motion-vector consumer.

Parameters:
- SEARCH_RANGE, 4, candidate positions per axis (1..32). The reference window is REF_W = SEARCH_RANGE+7 pixels square.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  start request; a search starts on a 0->1 transition sampled at a clock edge.
- cur_in_i  in  32  current-memory read data: 4 pixels, lowest column in [31:24].
- ref_in_i  in  64  reference-memory read data: 8 consecutive pixels, lowest column in [63:56].
- cur_mem_addr  out  32  word address 0..15; word k = block row k/2, columns 4*(k%2)..+3.
- ref_mem_addr  out  32  pixel address row*REF_W+col of the first of 8 pixels.
- cur_mem_en  out  1  current-memory read enable.
- ref_mem_en  out  1  reference-memory read enable.
- MSAD  out  14  minimum SAD; maximum value 64*255 = 16320.
- MSAD_column  out  5  horizontal displacement of the best match.
- MSAD_row  out  5  vertical displacement of the best match.
- data_valid  out  1  one-cycle pulse when the result is final.

Behaviour:
- Memories: data is valid in the same cycle as address and enable. With the enable low, read data is 0.
- Reset: the FSM goes to IDLE. All outputs are 0, including addresses and enables. The start edge detector is cleared. Reset has priority in every state and aborts any search in progress with no data_valid.
- IDLE: a start occurs when en_i is 1 and was 0 on the previous edge. A level held high after a search does not restart it; en_i must drop and rise again.
- LOAD (16 cycles):
  - cur_mem_en = 1, with cur_mem_addr stepping 0..15.
  - Each word is registered into an 8x8 pixel array at the clock edge of the cycle in which its address is presented.
- SEARCH (8*SEARCH_RANGE^2 cycles):
  - ref_mem_en = 1.
  - Candidates are visited in raster order: row r outer, column c inner, both 0..SEARCH_RANGE-1.
  - For each candidate, block rows i = 0..7 are fetched in order, with ref_mem_addr = (r+i)*REF_W + c.
  - Each cycle, compute the sum of the 8 absolute pixel differences against stored row i and accumulate it in a 14-bit register. The accumulator is cleared at each candidate start.
- Compare: after a candidate's 8th row, the candidate total is compared with the best so far. It replaces the best only if strictly less, so ties keep the earliest raster candidate. The first candidate always initialises the best.
- DONE (1 cycle):
  - data_valid = 1 and the enables are 0.
  - MSAD, MSAD_row and MSAD_column hold the best result.
  - The FSM then returns to IDLE.
- Latency: with the start edge sampled at edge N, data_valid is high in the cycle following edge N + 17 + 8*SEARCH_RANGE^2.
- Output hold: MSAD, MSAD_row and MSAD_column hold their values after DONE until the next start or reset. They are not guaranteed valid while a search is in progress.
- Addresses: 0 whenever the corresponding enable is 0.
- Arithmetic: differences are unsigned 8-bit |a-b|. Row sums are 11 bits; totals are 14 bits with no overflow possible.

Decomposition:
- Shared package me_pkg holds:
  - BLK = 8, PIX_W = 8, SAD_W = 14, COORD_W = 5;
  - the FSM state enum (IDLE, LOAD, SEARCH, DONE);
  - the address-layout constants.
- One natural sub-module: me_row_sad, a combinational 8-pixel absolute-difference adder tree (2x64-bit in, 11-bit out).
- cur_mem and ref_mem remain separate combinational bench memory models.

Test Plan:
- Exact match: the ref window is random except the current block copied at row 2, column 1 (SEARCH_RANGE = 4). Required: MSAD = 0x000 at (02,01) and one data_valid pulse.
- All-tie: cur all 0x10, ref all 0x00. Required: MSAD = 0x400 at (00,00).
- Saturation: cur all 0xFF, ref all 0x00. Required: MSAD = 0x3FC0 at (00,00), with no wrap.
- Timing and level behaviour: rst for 1 cycle, then en_i rises and is held high. Required:
  - cur_mem_en is high for exactly 16 cycles, then ref_mem_en for 128 cycles;
  - data_valid arrives at start+145;
  - no second pulse while en_i stays high.
- Reset mid-search: assert rst during SEARCH. Required:
  - all outputs are 0 the next cycle and no data_valid occurs;
  - a later en_i edge produces a correct full result.
- Retrigger: drop en_i, change the ref data so the best match is at (03,03), raise en_i. Required: MSAD = 0x000 at (03,03).
